// File: rtl/serial_display_scanner.sv
// Four-digit seven-segment front end: buffers the last four hex characters from the serial
// receiver and time-multiplexes them onto the display, with a blanking gap between digits.
module serial_display_scanner #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii_data_i,
    input  logic       data_valid_i,
    output logic [7:0] seven_segment_data_o,
    output logic [3:0] seven_segment_enable_o,
    output logic [2:0] digit_count_o,
    output logic       bad_char_o
);

    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic {StShow, StGap} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      filled_q, filled_d;
    logic            bad_q, bad_d;

    logic            is_hex;
    logic [3:0]      nibble;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        logic [7:0] s;
        unique case (v)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Letters A-F / a-f share the low nibble 1-6, so +9 gives 10-15 for both cases.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (ascii_data_i >= 8'h30 && ascii_data_i <= 8'h39) begin
            is_hex = 1'b1;
            nibble = ascii_data_i[3:0];
        end else if ((ascii_data_i >= 8'h41 && ascii_data_i <= 8'h46) ||
                     (ascii_data_i >= 8'h61 && ascii_data_i <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = ascii_data_i[3:0] + 4'd9;
        end
    end

    always_comb begin
        dig_d    = dig_q;
        filled_d = filled_q;
        bad_d    = 1'b0;
        if (data_valid_i) begin
            if (is_hex) begin
                dig_d    = {dig_q[2:0], nibble};
                filled_d = {filled_q[2:0], 1'b1};
            end else if (ascii_data_i == 8'h08) begin
                dig_d    = {4'h0, dig_q[3:1]};
                filled_d = {1'b0, filled_q[3:1]};
            end else if (ascii_data_i == 8'h1B) begin
                filled_d = 4'b0000;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StGap;
            idx_q    <= 2'd3;
            cnt_q    <= '0;
            dig_q    <= '0;
            filled_q <= 4'b0000;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            filled_q <= filled_d;
            bad_q    <= bad_d;
        end
    end

    // Everything below is decoded from registers only; no path from the character inputs.
    always_comb begin
        seven_segment_enable_o = 4'b1111;
        seven_segment_data_o   = 8'hFF;
        if (state_q == StShow) begin
            seven_segment_enable_o = ~(4'b0001 << idx_q);
            if (filled_q[idx_q]) begin
                seven_segment_data_o = seg_code(dig_q[idx_q]);
            end
        end
    end

    // filled is always a contiguous run from bit 0, so its popcount is the digit count.
    always_comb begin
        digit_count_o = {2'b00, filled_q[0]} + {2'b00, filled_q[1]} +
                        {2'b00, filled_q[2]} + {2'b00, filled_q[3]};
    end

    assign bad_char_o = bad_q;

endmodule

// File: tb/tb_serial_display_scanner.sv
// Directed bench for serial_display_scanner with REFRESH_DIV=4, BLANK_CYCLES=1 (20-cycle frame).
module tb_serial_display_scanner;

    logic       clk;
    logic       rst_n;
    logic [7:0] ascii_data;
    logic       data_valid;
    logic [7:0] seg_data;
    logic [3:0] seg_en;
    logic [2:0] digit_count;
    logic       bad_char;

    int errors = 0;
    int checks = 0;
    int t = 0;
    logic [7:0] exp_seg[4];

    serial_display_scanner #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ascii_data_i          (ascii_data),
        .data_valid_i          (data_valid),
        .seven_segment_data_o  (seg_data),
        .seven_segment_enable_o(seg_en),
        .digit_count_o         (digit_count),
        .bad_char_o            (bad_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // t counts rising edges since reset release; t=0 is the single initial GAP cycle.
    function automatic logic show_now(input int tt);
        return (tt > 0) && (((tt - 1) % 20) % 5 < 4);
    endfunction

    function automatic int slot_now(input int tt);
        return ((tt - 1) % 20) / 5;
    endfunction

    function automatic logic [3:0] exp_en(input int tt);
        if (!show_now(tt)) return 4'b1111;
        return ~(4'b0001 << slot_now(tt));
    endfunction

    function automatic logic [7:0] exp_data(input int tt);
        if (!show_now(tt)) return 8'hFF;
        return exp_seg[slot_now(tt)];
    endfunction

    task automatic cyc();
        @(posedge clk);
        t++;
        @(negedge clk);
        check("enable", 32'(seg_en), 32'(exp_en(t)));
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            check("segments", 32'(seg_data), 32'(exp_data(t)));
        end
    endtask

    task automatic send(input logic [7:0] c, input logic exp_bad);
        ascii_data = c;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        check("bad_char", 32'(bad_char), 32'(exp_bad));
        cyc();
        check("bad_clear", 32'(bad_char), 32'h0);
    endtask

    task automatic set_exp(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        exp_seg[0] = d0;
        exp_seg[1] = d1;
        exp_seg[2] = d2;
        exp_seg[3] = d3;
    endtask

    task automatic release_and_idle();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        check("gap_after_release_en", 32'(seg_en), 32'hF);
        check("gap_after_release_seg", 32'(seg_data), 32'hFF);
        set_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        frame(40);
    endtask

    initial begin
        rst_n      = 1'b0;
        ascii_data = 8'h00;
        data_valid = 1'b0;

        // Reset / idle
        repeat (3) @(negedge clk);
        check("rst_enable", 32'(seg_en), 32'hF);
        check("rst_segments", 32'(seg_data), 32'hFF);
        check("rst_count", 32'(digit_count), 32'h0);
        check("rst_bad", 32'(bad_char), 32'h0);
        release_and_idle();

        // Fill
        send("1", 1'b0);
        send("2", 1'b0);
        send("3", 1'b0);
        send("4", 1'b0);
        check("fill_count", 32'(digit_count), 32'd4);
        set_exp(8'h99, 8'h0D, 8'h25, 8'h9F);
        frame(20);

        // Overflow with lowercase
        send("a", 1'b0);
        check("overflow_count", 32'(digit_count), 32'd4);
        set_exp(8'h11, 8'h99, 8'h0D, 8'h25);
        frame(20);

        // Editing
        send(8'h08, 1'b0);
        send(8'h08, 1'b0);
        check("bs_count", 32'(digit_count), 32'd2);
        set_exp(8'h0D, 8'h25, 8'hFF, 8'hFF);
        frame(20);
        send(8'h1B, 1'b0);
        check("esc_count", 32'(digit_count), 32'd0);
        set_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        frame(20);

        // Held strobe: two high cycles are two characters
        ascii_data = "5";
        data_valid = 1'b1;
        cyc();
        cyc();
        data_valid = 1'b0;
        check("held_count", 32'(digit_count), 32'd2);
        set_exp(8'h49, 8'h49, 8'hFF, 8'hFF);
        frame(20);
        send(8'h1B, 1'b0);

        // Rejects leave a loaded buffer untouched
        send("7", 1'b0);
        send("G", 1'b1);
        send("z", 1'b1);
        send(8'h20, 1'b1);
        check("reject_count", 32'(digit_count), 32'd1);
        set_exp(8'h1F, 8'hFF, 8'hFF, 8'hFF);
        frame(20);

        // Asynchronous reset during SHOW of digit 2
        send("8", 1'b0);
        send("9", 1'b0);
        set_exp(8'h09, 8'h01, 8'h1F, 8'hFF);
        for (int k = 0; k < 40; k++) begin
            if (show_now(t) && slot_now(t) == 2) break;
            cyc();
        end
        check("slot2_enable", 32'(seg_en), 32'hB);
        check("slot2_segments", 32'(seg_data), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_enable", 32'(seg_en), 32'hF);
        check("async_segments", 32'(seg_data), 32'hFF);
        check("async_count", 32'(digit_count), 32'h0);
        @(negedge clk);
        release_and_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_display_scanner.md
# serial_display_scanner

Sequential front end for the 4-digit seven-segment display. Accepts one ASCII character per `data_valid` strobe from the serial receiver path and keeps the last four hex characters in a shift buffer. It time-multiplexes the buffer onto the shared segment bus `seven_segment_data` and the digit selects `seven_segment_enable`. A blanking gap between digits suppresses ghosting. Sits between the UART receiver and the board display pins.

## Interface
- `REFRESH_DIV`, default 50000: cycles each digit is driven (1 ms at 50 MHz); ≥1.
- `BLANK_CYCLES`, default 2: cycles of all-off between digits; ≥1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `ascii_data` in 8: received character; sampled only when `data_valid`=1.
- `data_valid` in 1: character strobe; level-sampled, one character per high cycle.
- `seven_segment_data` out 8: segment pattern for the selected digit; bit order {a,b,c,d,e,f,g,dp}; active-low.
- `seven_segment_enable` out 4: digit select, active-low; bit 0 is the rightmost digit.
- `digit_count` out 3: number of filled digits, 0–4.
- `bad_char` out 1: one-cycle pulse for a rejected character.

## Operation
- **Buffer.** `buf[3:0]` holds 4-bit nibbles; `filled[3:0]` marks which are valid. Entry 0 is the newest character and is shown on the rightmost digit.
- **Hex character.** Accepted characters are 0x30–0x39, 0x41–0x46 and 0x61–0x66, mapping to 0–F (lowercase equals uppercase).
  - Shifts the buffer left: `buf[i]`←`buf[i-1]`, then `buf[0]`←new nibble, `filled`←{`filled[2:0]`,1}.
  - On a fifth character the oldest nibble is discarded and `digit_count` saturates at 4.
- **0x08 (backspace).** Shifts right: `buf[i]`←`buf[i+1]`, `filled[3]`←0. `digit_count` decrements and saturates at 0; when empty it is a no-op.
- **0x1B (ESC).** Sets `filled` to 0 and `digit_count` to 0.
- **Any other character.** Buffer is unchanged; `bad_char`=1 in the following cycle.
- **Segment codes** (active-low): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, B=C1, C=63, D=85, E=61, F=71 (hex). An unfilled digit drives FF. dp is always off.
- **Scan FSM** (registers: `state`, `idx[1:0]`, `cnt`):
  - SHOW: enable = ~(1<<`idx`), data = code(`buf[idx]`) or FF if unfilled. After `REFRESH_DIV` cycles go to GAP, `cnt`←0.
  - GAP: enable=1111, data=FF. After `BLANK_CYCLES` cycles, `idx`←`idx`+1 mod 4 (3 wraps to 0) and go to SHOW.
- **Outputs** are decoded only from registered state (`state`, `idx`, `buf`, `filled`, flags). There is no combinational path from `ascii_data` or `data_valid`.

## Timing
- **Reset values:** state=GAP, `idx`=3, `cnt`=0, `filled`=0, `buf`=0. Outputs: `seven_segment_enable`=1111, `seven_segment_data`=FF, `digit_count`=0, `bad_char`=0.
- **After reset release:** GAP for `BLANK_CYCLES`, then SHOW of digit 0. Frame length is 4·(`REFRESH_DIV`+`BLANK_CYCLES`).
- **Character latency:** a character sampled at edge N updates `buf`/`digit_count` visible after edge N. It appears on the pins from that cycle only if the FSM is in SHOW with a matching `idx`; otherwise it appears at the next SHOW of that digit.
- **Update during SHOW:** the segment pattern changes mid-slot. Enable does not glitch, and the FSM is never stalled by input.
- **Held `data_valid`:** each high cycle is a separate character; there is no edge detection.
- **Asynchronous reset mid-frame:** all outputs go to their reset values immediately, without waiting for a clock edge, and the buffer is cleared.
- **Exclusivity:** at most one enable bit is low in any cycle.

## Test plan
Parameters for all scenarios: `REFRESH_DIV`=4, `BLANK_CYCLES`=1, giving a 20-cycle frame.
- **Reset/idle:** hold reset, release, and observe 40 cycles with no input. Expect enable=1111 with data FF during reset. After release, 1 GAP cycle, then enable sequence 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111 repeating (4/1 cycles each), and data always FF.
- **Fill:** send '1','2','3','4' as single-cycle strobes. Expect `digit_count`=4; the digit 0..3 slots show 99, 0D, 25, 9F.
- **Overflow and lowercase:** after the fill, send 'a'. Expect digits 0..3 = 11, 99, 0D, 25, with `digit_count` staying at 4.
- **Editing:** send 0x08 twice, then 0x1B.
  - After the backspaces: digit 0 = 0D, digit 1 = 25, digits 2–3 = FF, `digit_count`=2.
  - After ESC: all slots FF, `digit_count`=0.
- **Rejects:** send 'G', 'z', 0x20. Expect 3 `bad_char` pulses, one cycle each; buffer unchanged.
- **Asynchronous reset during a SHOW of digit 2 with data loaded:** expect enable=1111, data=FF, `digit_count`=0 without a clock edge, and the scan restarts as in the reset/idle scenario.
